// File: rtl/core_scheduler.sv
// Per-core control sequencer for the miniGPU: steps one lockstep instruction at a time
// through fetch/decode/load-store/execute and owns the per-thread program counters.
module core_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int ADDR_BITS   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUM_THREADS-1:0]           thread_mask,
    input  logic                             decoded_ret,
    input  logic [NUM_THREADS-1:0]           lsu_busy,
    input  logic [NUM_THREADS*ADDR_BITS-1:0] next_pc_flat,
    output logic [2:0]                       core_state,
    output logic [NUM_THREADS*ADDR_BITS-1:0] current_pc_flat,
    output logic [NUM_THREADS-1:0]           active_mask,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      instr_count
);

    // FETCH must stay 3'b001: the fetch unit keys on that encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } state_t;

    state_t                           state_r;
    logic [NUM_THREADS*ADDR_BITS-1:0] pc_r;
    logic [NUM_THREADS-1:0]           mask_r;
    logic                             busy_r;
    logic                             done_r;
    logic [15:0]                      count_r;
    logic                             lsu_pending_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Busy lanes of inactive threads never hold the core in WAIT.
    assign lsu_pending_s = |(lsu_busy & mask_r);

    // Sequencer state, PCs, launch mask, status flags and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= {(NUM_THREADS*ADDR_BITS){1'b0}};
            mask_r  <= {NUM_THREADS{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mask_r  <= thread_mask;
                        pc_r    <= {(NUM_THREADS*ADDR_BITS){1'b0}};
                        count_r <= 16'd0;
                        if (thread_mask != {NUM_THREADS{1'b0}}) begin
                            state_r <= ST_FETCH;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            // Nothing to run: report completion straight away.
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FETCH:   state_r <= ST_DECODE;
                ST_DECODE:  state_r <= ST_REQUEST;
                ST_REQUEST: state_r <= ST_WAIT;
                ST_WAIT: begin
                    if (lsu_pending_s) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: state_r <= ST_UPDATE;
                ST_UPDATE: begin
                    count_r <= sat_inc(count_r);
                    if (decoded_ret) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        // next_pc is taken verbatim, including any wrap produced upstream.
                        for (int i = 0; i < NUM_THREADS; i++) begin
                            if (mask_r[i]) begin
                                pc_r[i*ADDR_BITS +: ADDR_BITS] <= next_pc_flat[i*ADDR_BITS +: ADDR_BITS];
                            end
                        end
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign core_state      = state_r;
    assign current_pc_flat = pc_r;
    assign active_mask     = mask_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign instr_count     = count_r;

endmodule

// File: doc/core_scheduler.md
# core_scheduler

Per-core control sequencer for a miniGPU core. It owns the per-thread program counters and drives `core_state`, which steps the fetch, decode, load/store and execute stages through one instruction at a time. It feeds the instruction fetch unit the current per-thread PCs and accepts the per-thread next-PC values produced by the PC/branch units. It also tracks load/store completion, detects kernel return, and reports completion.

## Interface
Parameters:
- NUM_THREADS, 4, threads per core (lockstep)
- ADDR_BITS, 8, program address width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle launch pulse
- thread_mask  in  NUM_THREADS  active threads, sampled on accepted start
- decoded_ret  in  1  decoded instruction is RET; valid in EXECUTE/UPDATE
- lsu_busy  in  NUM_THREADS  per-thread load/store unit still servicing a request
- next_pc_flat  in  NUM_THREADS*ADDR_BITS  per-thread next PC, thread i at [i*ADDR_BITS +: ADDR_BITS]; valid in UPDATE
- core_state  out  3  current state encoding
- current_pc_flat  out  NUM_THREADS*ADDR_BITS  registered per-thread PCs, same packing
- active_mask  out  NUM_THREADS  registered copy of thread_mask
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  registered; high in DONE
- instr_count  out  16  instructions retired since launch, saturating

## Operation
- State encodings:
  - IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
  - FETCH must stay 001, because the fetch unit keys on it.
- IDLE:
  - If start=1: capture thread_mask into active_mask, clear all PCs and instr_count to 0, and set done=0.
  - If the captured mask is non-zero, go to FETCH. If it is 0, go to DONE.
- FETCH → DECODE → REQUEST unconditionally, one cycle each.
- REQUEST → WAIT unconditionally. The load/store unit samples its request in REQUEST.
- WAIT:
  - Stays in WAIT while (lsu_busy & active_mask) != 0; goes to EXECUTE when it is 0.
  - The minimum stay is 1 cycle.
  - lsu_busy bits of inactive threads are ignored.
- EXECUTE → UPDATE unconditionally.
- UPDATE:
  - instr_count increments by 1, saturating at 0xFFFF. This applies to RET as well.
  - If decoded_ret=1: go to DONE, set done=1, and leave the PCs unchanged.
  - Otherwise: for each thread i with active_mask[i]=1, pc[i] ← next_pc[i]; inactive threads hold. Then go to FETCH.
- PC arithmetic: next_pc is taken verbatim. Any wrap from 2^ADDR_BITS-1 to 0 is upstream's responsibility, and this block must not alter it.
- DONE:
  - Holds state; done=1.
  - start=1 relaunches exactly as from IDLE: the new mask is captured, PCs and instr_count are cleared, and done is cleared on the same edge.
- start is ignored in all states other than IDLE and DONE.
- Thread divergence is unsupported: instructions are fetched from thread 0's PC, and each thread's PC is updated only with its own next_pc.

## Timing
- Reset values:
  - core_state=000, all PCs 0, active_mask 0, busy 0, done 0, instr_count 0.
  - Reset asserted mid-operation forces these values immediately (asynchronously), regardless of state.
- All outputs are registered, and every state change occurs on the rising clk edge.
- Launch latency: with start=1 at edge n, core_state=FETCH after edge n.
- Instruction latency: minimum 6 cycles per instruction (FETCH, DECODE, REQUEST, 1×WAIT, EXECUTE, UPDATE). Each extra cycle that a masked lsu_busy stays high after WAIT entry adds 1 cycle.
- PC timing: an updated PC is visible on current_pc_flat in the FETCH cycle that follows UPDATE.
- done=1 and instr_count final are visible in the cycle after the UPDATE edge that saw decoded_ret=1.

## Test plan
- Reset: assert reset in any state → all outputs at their reset values within the same cycle, without a clock edge; release → remains IDLE with start=0.
- Straight-line stepping:
  - Stimulus: mask 4'b1111, lsu_busy=0, ret=0, bench next_pc=pc+1.
  - core_state sequence: 001,010,011,100,101,110,001.
  - After the first UPDATE: all PCs=1, instr_count=1.
- WAIT stall:
  - Hold lsu_busy=4'b0100 for the first 3 WAIT cycles → WAIT lasts 4 cycles, then EXECUTE.
  - With mask 4'b1011, lsu_busy=4'b0100 held → WAIT lasts exactly 1 cycle.
- Full program:
  - Stimulus: 11 instructions with ret=1 on the 11th.
  - DONE entered 66 cycles after the first FETCH; done=1, instr_count=11, PCs frozen at 10.
- Edge cases:
  - start with mask 0 → DONE after 1 edge, PCs 0, instr_count 0.
  - start in DONE with mask 4'b0011 → FETCH; PCs cleared, done=0.
  - Threads 2 and 3 hold their PCs across UPDATE.
  - next_pc=0xFF then 0x00 is accepted verbatim.
- start pulses in FETCH through UPDATE have no effect. Reset asserted during WAIT returns the block to IDLE with all outputs 0.
